ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 82 ++++++++
 tb/tb_ccff_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: streams host bytes MSB-first into a configuration flip-flop chain.
// Define CCFF_READBACK_EN to add a VERIFY pass that compares ccff_tail against a resupplied bitstream.
module ccff_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic       prog_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       ccff_tail,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] sbuf;
  logic [3:0] nbits;
  logic [15:0] cnt;
  logic active, shift, last, take;
  assign active = (state == LOAD) || (state == VERIFY);
  assign shift = active && (nbits != 4'd0);
  assign last = shift && (cnt == 16'(CHAIN_LEN - 1));
  assign cfg_ready = active && (nbits <= 4'd1);
  assign take = cfg_valid && cfg_ready;
  assign ccff_shift_en = shift;
  assign ccff_head = shift && sbuf[7];
  assign busy = active;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? LOAD : IDLE;
`ifdef CCFF_READBACK_EN
      LOAD: state_nxt = last ? VERIFY : LOAD;
`else
      LOAD: state_nxt = last ? DONE : LOAD;
`endif
      VERIFY: state_nxt = last ? DONE : VERIFY;
      DONE: state_nxt = start ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // Every state change starts a fresh phase; a partial byte left at the end is dropped here.
  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      state <= IDLE;
      sbuf <= 8'd0;
      nbits <= 4'd0;
      cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        sbuf <= 8'd0;
        nbits <= 4'd0;
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'(shift);
        sbuf <= take ? cfg_data : sbuf << 1;
        nbits <= take ? 4'd8 : nbits - 4'(shift);
      end
    end
  end
`ifdef CCFF_READBACK_EN
  logic err_r;
  always_ff @(posedge prog_clk) begin
    if (!reset || (state == IDLE && start))
      err_r <= 1'b0;
    else if (state == VERIFY && shift && (ccff_tail != ccff_head))
      err_r <= 1'b1;
  end
  assign err = err_r;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: scoreboard bench for ccff_loader driving a 16-bit and a 12-bit chain instance.
module tb_ccff_loader;
`ifdef CCFF_READBACK_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;
  logic reset;
  logic start[2], cfg_valid[2], cfg_ready[2], tail[2], head[2], shift_en[2], busy[2], done[2], err[2];
  logic [7:0] cfg_data[2];
  logic [15:0] ch16 = 16'd0;
  logic [11:0] ch12 = 12'd0;
  logic inj = 1'b0;
  bit q0[$];
  bit q1[$];
  int n_cmp = 0, n_bad = 0;
  int shifts[2];
  int cyc = 0, first_c = 0, c16 = 0;

  ccff_loader #(.CHAIN_LEN(16)) u16 (
    .prog_clk(prog_clk), .reset(reset), .start(start[0]), .cfg_valid(cfg_valid[0]),
    .cfg_data(cfg_data[0]), .cfg_ready(cfg_ready[0]), .ccff_tail(tail[0]), .ccff_head(head[0]),
    .ccff_shift_en(shift_en[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
  ccff_loader #(.CHAIN_LEN(12)) u12 (
    .prog_clk(prog_clk), .reset(reset), .start(start[1]), .cfg_valid(cfg_valid[1]),
    .cfg_data(cfg_data[1]), .cfg_ready(cfg_ready[1]), .ccff_tail(tail[1]), .ccff_head(head[1]),
    .ccff_shift_en(shift_en[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  // Behavioural chains; inj makes flip-flop 5 of the 16-bit chain store its input inverted.
  always @(posedge prog_clk) if (shift_en[0]) ch16 <= {ch16[14:0], head[0]} ^ (inj ? 16'h0020 : 16'h0000);
  always @(posedge prog_clk) if (shift_en[1]) ch12 <= {ch12[10:0], head[1]};
  assign tail[0] = ch16[15];
  assign tail[1] = ch12[11];
  always @(posedge prog_clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endfunction

  always @(negedge prog_clk) if (shift_en[0]) begin
    if (q0.size() == 0) chk("head16 unexpected shift", 1, 0);
    else chk("head16", head[0], q0.pop_front());
    if (shifts[0] == 0) first_c = cyc;
    if (shifts[0] == 15) c16 = cyc;
    shifts[0]++;
  end
  always @(negedge prog_clk) if (shift_en[1]) begin
    if (q1.size() == 0) chk("head12 unexpected shift", 1, 0);
    else chk("head12", head[1], q1.pop_front());
    shifts[1]++;
  end

  task automatic push(int d, logic [15:0] e, int n);
    for (int i = n - 1; i >= 0; i--) if (d == 0) q0.push_back(e[i]); else q1.push_back(e[i]);
  endtask

  task automatic send(int d, logic [7:0] b);
    bit ok = 0;
    cfg_valid[d] = 1'b1;
    cfg_data[d] = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (cfg_ready[d]) begin ok = 1; break; end
    end
    @(posedge prog_clk); #1;
    cfg_valid[d] = 1'b0;
    if (!ok) chk("send timeout", 0, 1);
  endtask

  task automatic wait_idle(int d);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (!shift_en[d]) begin ok = 1; break; end
    end
    if (!ok) chk("shift end timeout", 0, 1);
  endtask

  task automatic phase(int d, logic [7:0] b0, logic [7:0] b1, logic [15:0] e, int n, int gap);
    push(d, e, n);
    send(d, b0);
    if (gap > 0) begin
      wait_idle(d);
      repeat (gap) begin
        @(negedge prog_clk);
        chk("stall shift_en", shift_en[d], 0);
      end
      @(posedge prog_clk); #1;
    end
    send(d, b1);
    wait_idle(d);
  endtask

  task automatic load(int d, logic [7:0] b0, logic [7:0] b1, logic [15:0] e, int n, int gap);
    shifts[d] = 0;
    @(posedge prog_clk); #1;
    start[d] = 1'b1;
    @(posedge prog_clk); #1;
    start[d] = 1'b0;
    phase(d, b0, b1, e, n, gap);
`ifdef CCFF_READBACK_EN
    phase(d, b0, b1, e, n, 0);
`endif
    chk("done after last shift", done[d], 1);
    chk("busy in done", busy[d], 0);
    chk("shift count", shifts[d], n * PH);
  endtask

  task automatic to_idle(int d);
    @(posedge prog_clk); #1;
    start[d] = 1'b1;
    @(posedge prog_clk); #1;
    start[d] = 1'b0;
    @(negedge prog_clk);
    chk("done cleared", done[d], 0);
    chk("idle not busy", busy[d], 0);
    @(negedge prog_clk);
    chk("no load after done start", {busy[d], shift_en[d]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      cfg_valid[d] = 1'b0;
      cfg_data[d] = 8'h00;
      shifts[d] = 0;
    end
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("reset outs16", {head[0], shift_en[0], cfg_ready[0], busy[0], done[0], err[0]}, 0);
    chk("reset outs12", {head[1], shift_en[1], cfg_ready[1], busy[1], done[1], err[1]}, 0);
    @(posedge prog_clk); #1;
    reset = 1'b1;
    // A5,3C gapless into a 16-bit chain
    load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 0);
    chk("gapless span", c16 - first_c, 15);
    chk("err clean", err[0], 0);
    to_idle(0);
    // FF,0F into a 12-bit chain: last four bits discarded
    load(1, 8'hFF, 8'h0F, 16'h0FF0, 12, 0);
    chk("q12 drained", q1.size(), 0);
    to_idle(1);
    // host stall between bytes
    load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 3);
    to_idle(0);
    // start during LOAD is ignored
    fork
      load(0, 8'h5A, 8'hC3, 16'h5AC3, 16, 0);
      begin
        repeat (5) @(posedge prog_clk);
        #1 start[0] = 1'b1;
        @(posedge prog_clk); #1;
        start[0] = 1'b0;
        @(negedge prog_clk);
        chk("busy after start in load", busy[0], 1);
      end
    join
    to_idle(0);
    // reset at bit 7 of LOAD, then reload from bit 0
    shifts[0] = 0;
    push(0, 16'h00A5, 8);
    @(posedge prog_clk); #1;
    start[0] = 1'b1;
    @(posedge prog_clk); #1;
    start[0] = 1'b0;
    send(0, 8'hA5);
    for (int i = 0; i < 50 && shifts[0] < 7; i++) @(posedge prog_clk);
    #1 reset = 1'b0;
    @(posedge prog_clk); #1;
    reset = 1'b1;
    @(negedge prog_clk);
    chk("mid-load reset outs", {head[0], shift_en[0], cfg_ready[0], busy[0], done[0], err[0]}, 0);
    chk("bits before reset", shifts[0], 8);
    q0.delete();
    load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 0);
    to_idle(0);
`ifdef CCFF_READBACK_EN
    // corrupted chain flip-flop must raise a sticky err
    inj = 1'b1;
    load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 0);
    chk("err on corrupt chain", err[0], 1);
    repeat (3) @(negedge prog_clk);
    chk("err sticky in done", {done[0], err[0]}, 2'b11);
    inj = 1'b0;
`endif
    chk("q16 drained", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
